// File: rtl/eth_sched_pkg.sv
// Shared constants, state encoding and round-robin helper
// for the GMII transmit scheduler.
package eth_sched_pkg;

    localparam int DEF_NPORT   = 3;
    localparam int DEF_IFG     = 12;
    localparam int DEF_TIMEOUT = 4096;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_GRANT = 2'd1;
    localparam state_t S_GAP   = 2'd2;

    // Port visited at step off of a search that starts after last.
    function automatic int rr_pos(
        input int last,
        input int off,
        input int n
    );
        return (last + 1 + off) % n;
    endfunction

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Arbitration request/result bundle between the scheduler
// and its round-robin picker.
interface eth_tx_scheduler_if
    import eth_sched_pkg::*;
#(
    parameter int NPORT = DEF_NPORT
);

    localparam int IW = $clog2(NPORT);

    logic [NPORT-1:0] req;
    logic [IW-1:0]    last;
    logic             prio0;
    logic             valid;
    logic [IW-1:0]    idx;

    modport master (
        output req,
        output last,
        output prio0,
        input  valid,
        input  idx
    );

    modport slave (
        input  req,
        input  last,
        input  prio0,
        output valid,
        output idx
    );

endinterface

// File: rtl/eth_rr_pick.sv
// Combinational winner search: port-0 priority override,
// otherwise round-robin starting after the last grant.
module eth_rr_pick
    import eth_sched_pkg::*;
#(
    parameter int NPORT = DEF_NPORT
) (
    eth_tx_scheduler_if.slave pif
);

    localparam int IW = $clog2(NPORT);

    logic [IW-1:0] v_pos;

    // Walk backwards so the earliest hit in search order wins.
    always_comb begin
        pif.valid = 1'b0;
        pif.idx   = '0;
        v_pos     = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            v_pos = IW'(rr_pos(int'(pif.last), i, NPORT));
            if (pif.req[v_pos]) begin
                pif.valid = 1'b1;
                pif.idx   = v_pos;
            end
        end
        if (pif.prio0 && pif.req[0]) begin
            pif.valid = 1'b1;
            pif.idx   = '0;
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// GMII transmit arbiter: grants one requester per frame,
// enforces an inter-frame gap and a grant timeout.
module eth_tx_scheduler
    import eth_sched_pkg::*;
#(
    parameter int NPORT          = DEF_NPORT,
    parameter int PRIO0          = 1,
    parameter int IFG_CYCLES     = DEF_IFG,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NPORT-1:0]         req,
    input  logic [NPORT-1:0]         done,
    output logic [NPORT-1:0]         sel,
    input  logic [NPORT-1:0]         port_tx_en,
    input  logic [8*NPORT-1:0]       port_txd,
    output logic                     gmii_tx_en,
    output logic [7:0]               gmii_txd,
    output logic                     busy,
    output logic [$clog2(NPORT)-1:0] grant_id,
    output logic                     timeout_err
);

    localparam int IW = $clog2(NPORT);
    localparam int GW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int FW = $clog2(IFG_CYCLES) + 1;

    localparam logic [GW-1:0] G_LAST = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] F_LAST = FW'(IFG_CYCLES - 1);
    localparam logic [IW-1:0] P_LAST = IW'(NPORT - 1);

    state_t           r_state;
    logic [NPORT-1:0] r_sel;
    logic [IW-1:0]    r_last;
    logic [IW-1:0]    r_gid;
    logic [GW-1:0]    r_gcnt;
    logic [FW-1:0]    r_ifg;
    logic             r_tx_en;
    logic [7:0]       r_txd;

    logic             w_valid;
    logic [IW-1:0]    w_idx;
    logic             w_done_g;
    logic             w_tmo;
    logic             w_en;
    logic [7:0]       w_txd;

    eth_tx_scheduler_if #(.NPORT(NPORT)) u_pick_if ();

    assign u_pick_if.req   = req;
    assign u_pick_if.last  = r_last;
    assign u_pick_if.prio0 = (PRIO0 != 0);
    assign w_valid         = u_pick_if.valid;
    assign w_idx           = u_pick_if.idx;

    eth_rr_pick #(.NPORT(NPORT)) u_pick (
        .pif (u_pick_if.slave)
    );

    // Only the holder's done counts; done beats a same-cycle timeout.
    assign w_done_g = |(done & r_sel);
    assign w_tmo    = (r_state == S_GRANT)
                   && (r_gcnt == G_LAST)
                   && !w_done_g;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_last  <= P_LAST;
            r_gid   <= '0;
            r_gcnt  <= '0;
            r_ifg   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_sel   <= NPORT'(1) << w_idx;
                        r_last  <= w_idx;
                        r_gid   <= w_idx;
                        r_gcnt  <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_done_g || w_tmo) begin
                        r_sel   <= '0;
                        r_gcnt  <= '0;
                        r_ifg   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1);
                    end
                end
                S_GAP: begin
                    if (r_ifg == F_LAST) begin
                        r_ifg   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ifg <= r_ifg + FW'(1);
                    end
                end
                default: begin
                    r_sel   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_en  = |(r_sel & port_tx_en);
        w_txd = '0;
        for (int i = 0; i < NPORT; i++) begin
            w_txd = w_txd | (port_txd[8*i +: 8] & {8{r_sel[i]}});
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_en <= 1'b0;
            r_txd   <= '0;
        end else begin
            r_tx_en <= w_en;
            r_txd   <= w_txd;
        end
    end

    assign sel         = r_sel;
    assign gmii_tx_en  = r_tx_en;
    assign gmii_txd    = r_txd;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_gid;
    assign timeout_err = w_tmo;

endmodule
